// File: rtl/sigma_delta_pkg.sv
// Shared types and default constants for the sigma-delta ADC controller.
package sigma_delta_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RUN,
    ST_FLUSH
  } adc_ctrl_state_t;

  localparam int DEF_OVERSAMPLE_RATE = 256;
  localparam int DEF_ADC_BITLEN      = 24;
  localparam int DEF_SETTLE_SAMPLES  = 2;
  localparam int DEF_FIFO_DEPTH      = 4;

  // The decimation counter and busy flag only advance in these two states.
  function automatic logic is_active(input adc_ctrl_state_t s);
    return (s == ST_SETTLE) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/sigma_delta_sample_fifo.sv
// Sample buffer with a registered head word; pointers carry one extra wrap bit
// so full/empty come from comparing the pointer MSBs.
module sigma_delta_sample_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, wr_next, rd_next;
  logic             push_ok, pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign wr_next = push_ok ? wr_ptr + 1'b1 : wr_ptr;
  assign rd_next = pop_ok ? rd_ptr + 1'b1 : rd_ptr;

  // NOTE: storage is deliberately not reset; only pointers and head_data define visible state.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      head_data <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      // The new head may be the word being written this cycle, so bypass it.
      if (wr_next != rd_next)
        head_data <= (push_ok && (wr_ptr[AW-1:0] == rd_next[AW-1:0]))
                     ? push_data : mem[rd_next[AW-1:0]];
    end
  end

endmodule

// File: rtl/sigma_delta_adc_ctrl.sv
// Sigma-delta ADC controller: decimation tick, settle discard and output buffer.
// Optional drop counter port enabled by macro SIGMA_DELTA_ADC_CTRL_DROP_CNT_EN.
module sigma_delta_adc_ctrl
  import sigma_delta_pkg::*;
#(
  parameter int OVERSAMPLE_RATE = DEF_OVERSAMPLE_RATE,
  parameter int ADC_BITLEN      = DEF_ADC_BITLEN,
  parameter int SETTLE_SAMPLES  = DEF_SETTLE_SAMPLES,
  parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  output logic                  decim_strobe,
  input  logic                  cic_valid,
  input  logic [ADC_BITLEN-1:0] cic_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADC_BITLEN-1:0] out_data,
  output logic                  overrun,
  input  logic                  overrun_clr,
  output logic                  busy
`ifdef SIGMA_DELTA_ADC_CTRL_DROP_CNT_EN
  , output logic [15:0]         drop_count
`endif
);

  localparam int              CW          = $clog2(OVERSAMPLE_RATE);
  localparam logic [CW-1:0]   CNT_MAX     = CW'(OVERSAMPLE_RATE - 1);
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE_SAMPLES - 1);
  localparam bit              SKIP_SETTLE = (SETTLE_SAMPLES == 0);

  adc_ctrl_state_t state, state_next;
  logic [CW-1:0]   dcnt, dcnt_next;
  logic [3:0]      discard_cnt;
  logic            push, flush, drop, fifo_full, fifo_empty;

  assign push      = (state == ST_RUN) && cic_valid;
  assign flush     = (state == ST_FLUSH);
  assign drop      = push && fifo_full && !out_ready;
  assign out_valid = !fifo_empty;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (enable) state_next = SKIP_SETTLE ? ST_RUN : ST_SETTLE;
      ST_SETTLE: if (!enable) state_next = ST_FLUSH;
                 else if (cic_valid && (discard_cnt == SETTLE_LAST)) state_next = ST_RUN;
      ST_RUN:    if (!enable) state_next = ST_FLUSH;
      ST_FLUSH:  state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    dcnt_next = '0;
    if (is_active(state) && is_active(state_next))
      dcnt_next = (dcnt == CNT_MAX) ? '0 : dcnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      dcnt         <= '0;
      discard_cnt  <= '0;
      decim_strobe <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_next;
      dcnt         <= dcnt_next;
      decim_strobe <= is_active(state_next) && (dcnt_next == CNT_MAX);
      busy         <= is_active(state_next);
      if (state_next != ST_SETTLE)
        discard_cnt <= '0;
      else if ((state == ST_SETTLE) && cic_valid)
        discard_cnt <= discard_cnt + 1'b1;
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;
    end
  end

`ifdef SIGMA_DELTA_ADC_CTRL_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      drop_count <= '0;
    else if (overrun_clr)
      drop_count <= drop ? 16'd1 : 16'd0;
    else if (drop && (drop_count != 16'hFFFF))
      drop_count <= drop_count + 16'd1;
  end
`endif

  sigma_delta_sample_fifo #(
    .WIDTH (ADC_BITLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (cic_data),
    .pop       (out_ready),
    .flush     (flush),
    .head_data (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: doc/sigma_delta_adc_ctrl.md
SIGMA_DELTA_ADC_CTRL -- requirements
Module: sigma_delta_adc_ctrl

Interface
REQ-001 The block SHALL have parameter OVERSAMPLE_RATE, default 256, meaning clk cycles per decimated output (power of two, 2 to 4096).
REQ-002 The block SHALL have parameter ADC_BITLEN, default 24, meaning the signed CIC sample width.
REQ-003 The block SHALL have parameter SETTLE_SAMPLES, default 2, meaning the number of CIC outputs discarded after start (0 to 15).
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the output buffer entries (power of two, 2 to 16).
REQ-005 Port clk, input, 1 bit: the single clock, running at the oversample rate; all logic is on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 Port enable, input, 1 bit: level request to run the converter.
REQ-008 Port decim_strobe, output, 1 bit: one-cycle decimation tick to the CIC comb section.
REQ-009 Port cic_valid, input, 1 bit: the CIC presents a new sample.
REQ-010 Port cic_data, input, ADC_BITLEN bits: the signed CIC sample.
REQ-011 Port out_valid, output, 1 bit: output sample available.
REQ-012 Port out_ready, input, 1 bit: the consumer accepts; a transfer occurs when out_valid and out_ready are both high.
REQ-013 Port out_data, output, ADC_BITLEN bits: the head-of-buffer sample.
REQ-014 Port overrun, output, 1 bit: sticky flag that a sample was dropped.
REQ-015 Port overrun_clr, input, 1 bit: synchronous clear for overrun.
REQ-016 Port busy, output, 1 bit: high in SETTLE or RUN.

Function
REQ-017 The FSM SHALL have states IDLE, SETTLE, RUN and FLUSH.
- IDLE→SETTLE when enable=1.
- SETTLE→RUN when the discard count reaches SETTLE_SAMPLES; immediately if SETTLE_SAMPLES=0.
- SETTLE/RUN→FLUSH when enable=0.
- FLUSH→IDLE after one cycle.
REQ-018 The decimation counter SHALL have width $clog2(OVERSAMPLE_RATE) and load 0 on entry to SETTLE.
- It increments each cycle in SETTLE and RUN, wrapping from OVERSAMPLE_RATE-1 to 0.
- It holds 0 in IDLE and FLUSH.
REQ-019 decim_strobe SHALL be high exactly in cycles where the counter equals OVERSAMPLE_RATE-1 in SETTLE or RUN, giving first strobe OVERSAMPLE_RATE cycles after the enable edge is sampled.
REQ-020 cic_valid in IDLE or FLUSH SHALL be ignored; in SETTLE each cic_valid SHALL increment the discard count and not be buffered.
REQ-021 In RUN, cic_valid SHALL push cic_data into the FIFO unmodified; a push into an empty FIFO SHALL give out_valid=1 on the next cycle (one-cycle latency).
REQ-022 Push while full without a simultaneous pop SHALL drop the new sample, keep FIFO contents, and set overrun.
- Push and pop in the same cycle while full SHALL both succeed.
REQ-023 Pop on an empty FIFO SHALL be a no-op; out_data SHALL hold its last value while out_valid=0.
REQ-024 Entry to FLUSH SHALL empty the FIFO and force out_valid=0 in the following cycle; buffered samples are discarded.
REQ-025 overrun_clr SHALL clear overrun; a drop in the same cycle SHALL win (overrun stays 1).
REQ-026 FIFO pointers SHALL be $clog2(FIFO_DEPTH)+1 bits with natural wrap; full and empty are decided by the MSB compare.

Reset
REQ-027 On rst the block SHALL asynchronously return to these values:
- state IDLE, counter 0, discard count 0, FIFO empty.
- decim_strobe=0, out_valid=0, out_data=0, overrun=0, busy=0.
REQ-028 rst asserted mid-RUN SHALL discard buffered data with no handshake completion; operation resumes via SETTLE on release.

Configuration
REQ-029 With macro SIGMA_DELTA_ADC_CTRL_DROP_CNT_EN defined, the block SHALL add output drop_count (16 bits, saturating at 65535, cleared by rst and overrun_clr) counting dropped samples.
- Without the macro, the port and counter SHALL be absent and behaviour is otherwise identical.

Structure
REQ-030 Package sigma_delta_pkg SHALL hold the adc_ctrl_state_t enum and default constants for OVERSAMPLE_RATE, ADC_BITLEN and SETTLE_SAMPLES.
REQ-031 The buffer SHALL be the sub-module sigma_delta_sample_fifo, with parameters width and depth, a push/pop/flush interface, and full/empty outputs.

Verification
REQ-032 Scenario: OSR=256, enable at cycle 10 → decim_strobe pulses at cycles 266, 522, 778, …, each one cycle wide.
REQ-033 Scenario: SETTLE_SAMPLES=2, cic_valid with data 100, 200, 300 → only 300 appears at out_data, out_valid one cycle after the push.
REQ-034 Scenario: out_ready=0 with 5 pushes of 1..5 in RUN, FIFO_DEPTH=4 → 1..4 are retained, 5 is dropped, overrun=1, and drop_count=1 when the macro is defined.
REQ-035 Scenario: full FIFO with push and pop in the same cycle → pop returns the head, push is accepted, overrun stays 0.
REQ-036 Scenario: enable dropped in RUN with 3 buffered samples → FLUSH then IDLE, out_valid=0, busy=0 two cycles later.
REQ-037 Scenario: rst pulse mid-RUN (not aligned to clk) → all outputs are at reset values immediately; re-enable replays the settle discard.
